// File: rtl/prover_shuffle_pkg.sv
// rtl/prover_shuffle_pkg.sv - state type and round-geometry helpers for prover_shuffle_rounds
package prover_shuffle_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_FIN
    } state_t;

    // Each round halves the live array: round k consumes nValues>>k values as pairs.
    function automatic int pairs_in_round(input int n_val_bits, input int k);
        return (1 << n_val_bits) >> (k + 1);
    endfunction

    function automatic int beats_in_round(input int n_val_bits, input int k, input int n_par_bits);
        int b;
        b = pairs_in_round(n_val_bits, k) >> n_par_bits;
        return (b < 1) ? 1 : b;
    endfunction

    function automatic int round_width(input int n_val_bits);
        return (n_val_bits <= 2) ? 1 : $clog2(n_val_bits);
    endfunction

    function automatic int beat_width(input int n_val_bits, input int n_par_bits);
        int w;
        w = n_val_bits - 1 - n_par_bits;
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/prover_shuffle_rounds_ctl.sv
// rtl/prover_shuffle_rounds_ctl.sv - round/beat sequencer, handshake FSM and lane mask generation
module prover_shuffle_rounds_ctl
    import prover_shuffle_pkg::*;
#(
    parameter int nValBits = 4,
    parameter int nParBits = 1,
    localparam int P  = 1 << nParBits,
    localparam int RW = round_width(nValBits),
    localparam int BW = beat_width(nValBits, nParBits)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          restart,
    input  logic          out_ready,
    input  logic          red_valid,
    output logic          out_valid,
    output logic          wr_en,
    output logic          round_done,
    output logic          busy,
    output logic          done,
    output logic [RW-1:0] round,
    output logic [BW-1:0] beat,
    output logic [P-1:0]  lane_mask
);

    state_t        state, state_d;
    logic [RW-1:0] round_d;
    logic [BW-1:0] beat_d;
    logic          busy_d, done_d, round_done_d;
    int            pairs;
    logic          last_beat;

    // Only the final rounds have fewer pairs than lanes, and those have a single beat.
    always_comb begin
        pairs     = pairs_in_round(nValBits, int'(round));
        last_beat = (int'(beat) == beats_in_round(nValBits, int'(round), nParBits) - 1);
        lane_mask = '0;
        for (int l = 0; l < P; l++) begin
            lane_mask[l] = (l < pairs);
        end
    end

    assign out_valid = (state == S_SEND);
    assign wr_en     = (state == S_WAIT) && red_valid && !restart;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            round      <= '0;
            beat       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            round_done <= 1'b0;
        end else begin
            state      <= state_d;
            round      <= round_d;
            beat       <= beat_d;
            busy       <= busy_d;
            done       <= done_d;
            round_done <= round_done_d;
        end
    end

    always_comb begin
        state_d      = state;
        round_d      = round;
        beat_d       = beat;
        busy_d       = busy;
        done_d       = done;
        round_done_d = 1'b0;
        if (restart) begin
            state_d = S_SEND;
            round_d = '0;
            beat_d  = '0;
            busy_d  = 1'b1;
            done_d  = 1'b0;
        end else begin
            case (state)
                S_SEND: begin
                    if (out_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (red_valid) begin
                        if (last_beat) begin
                            round_done_d = 1'b1;
                            beat_d       = '0;
                            if (int'(round) == nValBits - 1) begin
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                                state_d = S_FIN;
                            end else begin
                                round_d = round + RW'(1);
                                state_d = S_SEND;
                            end
                        end else begin
                            beat_d  = beat + BW'(1);
                            state_d = S_SEND;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/prover_shuffle_rounds.sv
// rtl/prover_shuffle_rounds.sv - multi-round sumcheck value store with in-place compacting writeback
`ifndef F_NBITS
`define F_NBITS 32
`endif

module prover_shuffle_rounds
    import prover_shuffle_pkg::*;
#(
    parameter int nValBits = 4,
    parameter int nParBits = 1,
    localparam int NV = 1 << nValBits,
    localparam int P  = 1 << nParBits,
    localparam int F  = `F_NBITS,
    localparam int RW = round_width(nValBits)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   restart,
    input  logic [NV-1:0][F-1:0]   vals_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [P-1:0][F-1:0]    pair_even,
    output logic [P-1:0][F-1:0]    pair_odd,
    output logic [P-1:0]           lane_mask,
    output logic [RW-1:0]          round,
    input  logic                   red_valid,
    input  logic [P-1:0][F-1:0]    red_in,
    output logic                   round_done,
    output logic                   busy,
    output logic                   done,
    output logic [NV-1:0][F-1:0]   vals_out
);

    localparam int BW = beat_width(nValBits, nParBits);

    logic [NV-1:0][F-1:0]       vals;
    logic [BW-1:0]              beat;
    logic                       wr_en;
    logic [P-1:0][nValBits-1:0] wr_idx, ev_idx, od_idx;

    prover_shuffle_rounds_ctl #(
        .nValBits (nValBits),
        .nParBits (nParBits)
    ) u_ctl (
        .clk        (clk),
        .rst        (rst),
        .restart    (restart),
        .out_ready  (out_ready),
        .red_valid  (red_valid),
        .out_valid  (out_valid),
        .wr_en      (wr_en),
        .round_done (round_done),
        .busy       (busy),
        .done       (done),
        .round      (round),
        .beat       (beat),
        .lane_mask  (lane_mask)
    );

    // Lane l of beat b owns pair j = b*P+l; unmasked lanes may wrap but are never used.
    always_comb begin
        wr_idx    = '0;
        ev_idx    = '0;
        od_idx    = '0;
        pair_even = '0;
        pair_odd  = '0;
        for (int l = 0; l < P; l++) begin
            wr_idx[l] = nValBits'(int'(beat) * P + l);
            ev_idx[l] = nValBits'(2 * (int'(beat) * P + l));
            od_idx[l] = nValBits'(2 * (int'(beat) * P + l) + 1);
            if (lane_mask[l]) begin
                pair_even[l] = vals[ev_idx[l]];
                pair_odd[l]  = vals[od_idx[l]];
            end
        end
    end

    // Beat b writes below (b+1)P while later beats read from 2(b+1)P up, so in-place is safe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vals <= '0;
        end else if (restart) begin
            vals <= vals_in;
        end else if (wr_en) begin
            for (int l = 0; l < P; l++) begin
                if (lane_mask[l]) begin
                    vals[wr_idx[l]] <= red_in[l];
                end
            end
        end
    end

    assign vals_out = vals;

endmodule

// File: tb/tb_prover_shuffle_rounds.sv
// tb/tb_prover_shuffle_rounds.sv - self-checking bench for prover_shuffle_rounds
`ifndef F_NBITS
`define F_NBITS 32
`endif

`timescale 1ns/1ps
module tb_prover_shuffle_rounds;

    localparam int F = `F_NBITS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, restart_a, restart_b, out_ready, red_valid;
    logic [15:0][F-1:0] vals_in_a;
    logic [31:0][F-1:0] vals_in_b;
    logic [7:0][F-1:0]  red_in;

    logic               a_valid, a_rdone, a_busy, a_done;
    logic [1:0][F-1:0]  a_even, a_odd;
    logic [1:0]         a_mask;
    logic [1:0]         a_round;
    logic [15:0][F-1:0] a_vals;

    logic               b_valid, b_rdone, b_busy, b_done;
    logic [7:0][F-1:0]  b_even, b_odd;
    logic [7:0]         b_mask;
    logic [2:0]         b_round;
    logic [31:0][F-1:0] b_vals;

    prover_shuffle_rounds #(.nValBits(4), .nParBits(1)) u_a (
        .clk(clk), .rst(rst), .restart(restart_a), .vals_in(vals_in_a),
        .out_valid(a_valid), .out_ready(out_ready), .pair_even(a_even), .pair_odd(a_odd),
        .lane_mask(a_mask), .round(a_round), .red_valid(red_valid), .red_in(red_in[1:0]),
        .round_done(a_rdone), .busy(a_busy), .done(a_done), .vals_out(a_vals)
    );

    prover_shuffle_rounds #(.nValBits(5), .nParBits(3)) u_b (
        .clk(clk), .rst(rst), .restart(restart_b), .vals_in(vals_in_b),
        .out_valid(b_valid), .out_ready(out_ready), .pair_even(b_even), .pair_odd(b_odd),
        .lane_mask(b_mask), .round(b_round), .red_valid(red_valid), .red_in(red_in),
        .round_done(b_rdone), .busy(b_busy), .done(b_done), .vals_out(b_vals)
    );

    int sel = 0;
    logic               o_valid, o_rdone, o_busy, o_done;
    int                 o_round;
    logic [7:0]         o_mask;
    logic [7:0][F-1:0]  o_even, o_odd;
    logic [31:0][F-1:0] o_vals;

    always_comb begin
        o_even = '0;
        o_odd  = '0;
        o_vals = '0;
        o_mask = '0;
        if (sel == 0) begin
            o_valid = a_valid; o_rdone = a_rdone; o_busy = a_busy; o_done = a_done;
            o_round = int'(a_round);
            o_mask[1:0] = a_mask;
            o_even[1:0] = a_even;
            o_odd[1:0]  = a_odd;
            o_vals[15:0] = a_vals;
        end else begin
            o_valid = b_valid; o_rdone = b_rdone; o_busy = b_busy; o_done = b_done;
            o_round = int'(b_round);
            o_mask = b_mask;
            o_even = b_even;
            o_odd  = b_odd;
            o_vals = b_vals;
        end
    end

    int n_assert = 0;
    int n_fail   = 0;
    int nvb, npb, nv, np;
    logic [F-1:0] cur [32];
    logic [F-1:0] total;
    int mask_a [4] = '{3, 3, 3, 1};
    int mask_b [5] = '{8'hFF, 8'hFF, 8'h0F, 8'h03, 8'h01};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fills the reference array: 0 -> i, 1 -> 2i, 2 -> random, else all ones.
    task automatic load(input int which, input int pattern);
        sel = which;
        nvb = which ? 5 : 4;
        npb = which ? 3 : 1;
        nv  = 1 << nvb;
        np  = 1 << npb;
        total = '0;
        for (int i = 0; i < 32; i++) begin
            case (pattern)
                0:       cur[i] = F'(i);
                1:       cur[i] = F'(2 * i);
                2:       cur[i] = F'($urandom);
                default: cur[i] = F'(1);
            endcase
            if (i < nv) total += cur[i];
        end
        for (int i = 0; i < 16; i++) vals_in_a[i] = cur[i];
        for (int i = 0; i < 32; i++) vals_in_b[i] = cur[i];
    endtask

    task automatic pulse_restart();
        if (sel != 0) restart_b = 1'b1; else restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        restart_b = 1'b0;
    endtask

    task automatic handshake_wait(input string tag);
        int waited = 0;
        while (!o_valid && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_out_valid"}, o_valid, 1);
    endtask

    task automatic do_beat(input int k, input int b, input int pairs, input bit last, input bit fin, input bit stall);
        logic [7:0][F-1:0]  se, so;
        logic [31:0][F-1:0] sv;
        handshake_wait("beat");
        chk("round", o_round, k);
        chk("busy", o_busy, 1);
        for (int l = 0; l < np; l++) begin
            int j;
            j = b * np + l;
            chk("lane_mask", o_mask[l], (j < pairs));
            chk("pair_even", o_even[l], (j < pairs) ? cur[2 * j] : '0);
            chk("pair_odd",  o_odd[l],  (j < pairs) ? cur[2 * j + 1] : '0);
        end
        if (stall) begin
            se = o_even; so = o_odd; sv = o_vals;
            for (int c = 0; c < 5; c++) begin
                red_valid = 1'b1;
                for (int l = 0; l < 8; l++) red_in[l] = F'($urandom);
                @(negedge clk);
                chk("stall_valid", o_valid, 1);
                chk("stall_pairs", (o_even == se) && (o_odd == so), 1);
                chk("stall_vals", (o_vals == sv), 1);
            end
            red_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("wait_valid", o_valid, 0);
        chk("wait_round_done", o_rdone, 0);
        if ($urandom_range(0, 1) == 1) begin
            @(negedge clk);
            chk("wait_hold", o_valid, 0);
        end
        red_valid = 1'b1;
        for (int l = 0; l < 8; l++) begin
            int j;
            j = b * np + l;
            red_in[l] = (l < np && j < pairs) ? F'(cur[2 * j] + cur[2 * j + 1]) : F'($urandom);
        end
        @(negedge clk);
        red_valid = 1'b0;
        chk("round_done", o_rdone, last);
        chk("post_valid", o_valid, !fin);
        chk("done", o_done, fin);
        if (last && !fin) chk("round_inc", o_round, k + 1);
        if (fin) chk("busy_end", o_busy, 0);
    endtask

    task automatic do_round(input int k, input bit stall);
        logic [F-1:0] nxt [32];
        int pairs, beats;
        pairs = nv >> (k + 1);
        beats = ((pairs >> npb) == 0) ? 1 : (pairs >> npb);
        nxt = cur;
        for (int j = 0; j < pairs; j++) nxt[j] = cur[2 * j] + cur[2 * j + 1];
        for (int b = 0; b < beats; b++)
            do_beat(k, b, pairs, b == beats - 1, (k == nvb - 1) && (b == beats - 1), stall && b == 0);
        cur = nxt;
        for (int j = 0; j < nv; j++) chk("round_vals", o_vals[j], cur[j]);
    endtask

    task automatic finish_check(input logic [F-1:0] exp);
        chk("result", o_vals[0], exp);
        chk("result_model", o_vals[0], total);
        repeat (3) @(negedge clk);
        chk("done_hold", o_done, 1);
        chk("fin_valid", o_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; restart_a = 1'b0; restart_b = 1'b0; out_ready = 1'b0; red_valid = 1'b0;
        vals_in_a = '0; vals_in_b = '0; red_in = '0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            chk("rst_valid", o_valid, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_done", o_done, 0);
            chk("rst_round", o_round, 0);
            chk("rst_round_done", o_rdone, 0);
            chk("rst_vals", (o_vals == '0), 1);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Ascending values on the 2-lane instance, with directed first-beat and round-0 checks.
        load(0, 0);
        pulse_restart();
        chk("first_even1", o_even[1], 2);
        chk("first_even0", o_even[0], 0);
        chk("first_odd1", o_odd[1], 3);
        chk("first_odd0", o_odd[0], 1);
        for (int k = 0; k < 4; k++) begin
            chk("mask_tbl_a", o_mask, mask_a[k]);
            do_round(k, 0);
            if (k == 0) for (int i = 0; i < 8; i++) chk("r0_vals", o_vals[i], 4 * i + 1);
        end
        finish_check(120);

        // Consumer stall on round 1 beat 0, with stray red_valid during SEND.
        load(0, 0);
        pulse_restart();
        for (int k = 0; k < 4; k++) do_round(k, k == 1);
        finish_check(120);

        // restart collides with red_valid while waiting in round 2.
        load(0, 2);
        pulse_restart();
        do_round(0, 0);
        do_round(1, 0);
        handshake_wait("r2");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        for (int l = 0; l < 8; l++) red_in[l] = F'($urandom);
        red_valid = 1'b1;
        load(0, 1);
        restart_a = 1'b1;
        @(negedge clk);
        restart_a = 1'b0;
        red_valid = 1'b0;
        chk("rs_round", o_round, 0);
        chk("rs_valid", o_valid, 1);
        chk("rs_round_done", o_rdone, 0);
        chk("rs_busy", o_busy, 1);
        for (int i = 0; i < 16; i++) chk("rs_vals", o_vals[i], 2 * i);
        for (int k = 0; k < 4; k++) do_round(k, 0);
        finish_check(240);

        // Asynchronous reset in the middle of round 1.
        load(0, 2);
        pulse_restart();
        do_round(0, 0);
        handshake_wait("r1");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        red_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("mr_valid", o_valid, 0);
        chk("mr_busy", o_busy, 0);
        chk("mr_done", o_done, 0);
        chk("mr_round", o_round, 0);
        chk("mr_vals", (o_vals == '0), 1);
        rst = 1'b0;
        red_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_valid", o_valid, 0);
        chk("idle_round_done", o_rdone, 0);
        load(0, 2);
        pulse_restart();
        for (int k = 0; k < 4; k++) do_round(k, 0);
        finish_check(total);

        // 8-lane instance over 32 values: all ones, then random.
        load(1, 3);
        pulse_restart();
        for (int k = 0; k < 5; k++) begin
            chk("mask_tbl_b", o_mask, mask_b[k]);
            do_round(k, 0);
        end
        finish_check(32);
        load(1, 2);
        pulse_restart();
        for (int k = 0; k < 5; k++) do_round(k, k == 2);
        finish_check(total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/prover_shuffle_rounds.md
Name: prover_shuffle_rounds

Overview:
Multi-round sumcheck value store for the prover. It loads 2^nValBits field elements and, over nValBits rounds, presents even/odd pairs to 2^nParBits parallel reduction lanes. It writes the lanes' reduced values back in place, compacting the array. It generalises the single-pass shuffle: lane count is parametric, there is a ready/valid output handshake, in-place writeback with lane masking in late rounds, and a round counter with a done flag.

Parameters:
nValBits, 4, log2 of value count; nValues = 1<<nValBits.
nParBits, 1, log2 of lane count; P = 1<<nParBits; legal range 0 <= nParBits < nValBits.
Element width is `F_NBITS from the field header; it is not a parameter.

Ports:
clk  in  1  sole clock.
rst  in  1  reset; one clock; reset is asynchronous and active-high.
restart  in  1  load vals_in and begin round 0; legal in any state.
vals_in  in  nValues x F_NBITS  initial values, sampled only on restart.
out_valid  out  1  pair beat valid.
out_ready  in  1  consumer accepts beat.
pair_even  out  P x F_NBITS  lane l = v[2j], where j = beat*P+l.
pair_odd  out  P x F_NBITS  lane l = v[2j+1].
lane_mask  out  P  lane l valid iff j < pairs in current round.
round  out  max(1,$clog2(nValBits))  current round index.
red_valid  in  1  reduced beat returned.
red_in  in  P x F_NBITS  reduced value per lane.
round_done  out  1  one-cycle pulse at round completion.
busy  out  1  high from restart until final writeback.
done  out  1  high after the final round, held until restart or reset.
vals_out  out  nValues x F_NBITS  storage contents; vals_out[0] is the result when done.

Behaviour:
- Reset: storage, round, beat counter, out_valid, round_done, busy and done all 0; state IDLE.
- States: IDLE, SEND, WAIT, FIN.
- restart (any state): storage <= vals_in; round=0; beat=0; busy=1; done=0; next state SEND. restart beats every other event in the same cycle, including red_valid and the handshake.
- SEND: out_valid=1. Pair and mask outputs are driven combinationally from storage and are stable while stalled. On out_valid&out_ready the next state is WAIT.
- WAIT: out_valid=0. On red_valid, for each lane with lane_mask[l]=1, v[j] <= red_in[l]. Masked lanes are ignored. red_valid outside WAIT is ignored.
- In-place safety: writes of beat b hit indices < (b+1)P. Reads of later beats start at 2(b+1)P. No hazard exists, and no shadow copy is needed.
- Pairs in round k = nValues>>(k+1). Beats in round k = max(1, pairs>>nParBits). When pairs < P, only the low lanes are set in lane_mask.
- After the last beat's writeback:
  - If round < nValBits-1: round_done pulses for one cycle, round increments, beat=0, next state SEND. out_valid rises in the same cycle as round_done.
  - If it is the last round: round_done pulses, busy=0, done=1, next state FIN.
- FIN: holds until restart.
- Latency: restart edge to out_valid is 1 cycle. Handshake to next out_valid is ≥2 cycles (1 cycle of WAIT minimum).
- Masked lanes output 0 on pair_even/pair_odd.
- No arithmetic is done in this block. Values are stored verbatim; reduction belongs to the consumer.
- rst mid-operation returns to the reset state immediately. Storage is cleared. No pulses are emitted.

Decomposition:
- Package prover_shuffle_pkg:
  - State enum.
  - Function pairs_in_round(k).
  - Function beats_in_round(k, nParBits).
  - Round-counter width function.
  - `F_NBITS comes from the shared field header, not the package.
- One sub-module: prover_shuffle_rounds_ctl, which holds the FSM, round/beat counters and mask generation.
- The top level holds storage plus the read and writeback muxes.

Test Plan:
- Defaults (nValBits=4, nParBits=1), v[i]=i, consumer returns even+odd with out_ready=1 and red_valid 1 cycle later:
  - beats per round are 4,2,1,1 (8 total);
  - lane_mask is 11,11,11,01;
  - round_done pulses 4 times;
  - done=1 with vals_out[0]=120.
- Same configuration, first beat pair_even={2,0}, pair_odd={3,1} (lane1,lane0); after round 0 writeback, v[0..7]={1,5,9,13,17,21,25,29}.
- Stall: out_ready held low for 5 cycles on round 1 beat 0 -> pair outputs constant, no writeback; final result still 120.
- restart asserted during WAIT of round 2, same cycle as red_valid, with v[i]=2i -> red ignored; round=0; final vals_out[0]=240.
- rst pulse in round 1 -> next cycle all outputs 0, state IDLE, done=0; a subsequent restart completes normally.
- nValBits=5, nParBits=3, v[i]=1 -> beats 2,1,1,1,1; lane_mask 0xFF,0xFF,0x0F,0x03,0x01; vals_out[0]=32.
